// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: OFF, BLINK, CHASE and PWM modes driven
// from a shared tick prescaler, with run-time writable mode, period and duty.
module led_pattern_gen #(
  parameter int                 NUM_LED      = 4,
  parameter int                 CNT_W        = 26,
  parameter logic [CNT_W-1:0]   T_DEFAULT    = CNT_W'(24_999_999),
  parameter int                 PWM_W        = 8,
  parameter logic [PWM_W-1:0]   DUTY_DEFAULT = PWM_W'(128)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode_i,
  input  logic               mode_we,
  input  logic [CNT_W-1:0]   period_i,
  input  logic               period_we,
  input  logic [PWM_W-1:0]   duty_i,
  input  logic               duty_we,
  output logic [NUM_LED-1:0] led,
  output logic               tick,
  output logic [1:0]         mode_o
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_PWM   = 2'd3
  } mode_t;

  localparam logic [NUM_LED-1:0] CHASE_INIT = NUM_LED'(1);

  mode_t              mode_q,    mode_d;
  logic [CNT_W-1:0]   period_q,  period_d;
  logic [PWM_W-1:0]   duty_q,    duty_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [NUM_LED-1:0] led_q,     led_d;
  logic               tick_q,    tick_d;

  logic load;
  logic wrap;

  // Write strobes are single-cycle and always accepted, even with en low.
  // Any mode or period write restarts the prescaler and suppresses the wrap.
  assign load = mode_we | period_we;
  assign wrap = en & ~load & (cnt_q == period_q);

  always_comb begin
    mode_d    = mode_q;
    period_d  = period_q;
    duty_d    = duty_q;
    cnt_d     = cnt_q;
    pwm_cnt_d = pwm_cnt_q;
    led_d     = led_q;
    tick_d    = 1'b0;

    if (en) begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      cnt_d     = wrap ? '0 : cnt_q + 1'b1;
      tick_d    = wrap;
      case (mode_q)
        MODE_OFF:   led_d = '0;
        MODE_BLINK: if (wrap) led_d = ~led_q;
        MODE_CHASE: if (wrap) led_d = {led_q[NUM_LED-2:0], led_q[NUM_LED-1]};
        MODE_PWM:   led_d = {NUM_LED{pwm_cnt_q < duty_q}};
        default:    led_d = '0;
      endcase
    end

    if (load)      cnt_d    = '0;
    if (period_we) period_d = period_i;
    if (duty_we)   duty_d   = duty_i;

    // A mode write (even of the current mode) restarts the pattern from its
    // initial state; CHASE is the only mode that starts with a lit LED.
    if (mode_we) begin
      mode_d    = mode_t'(mode_i);
      pwm_cnt_d = '0;
      led_d     = (mode_t'(mode_i) == MODE_CHASE) ? CHASE_INIT : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_OFF;
      period_q  <= T_DEFAULT;
      duty_q    <= DUTY_DEFAULT;
      cnt_q     <= '0;
      pwm_cnt_q <= '0;
      led_q     <= '0;
      tick_q    <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      period_q  <= period_d;
      duty_q    <= duty_d;
      cnt_q     <= cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
      tick_q    <= tick_d;
    end
  end

  assign led    = led_q;
  assign tick   = tick_q;
  assign mode_o = mode_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: a behavioural model predicts
// {led, tick, mode_o} per cycle into a queue that a monitor drains.
module tb_led_pattern_gen;

  localparam int NUM_LED = 4;
  localparam int CNT_W   = 26;
  localparam int PWM_W   = 8;
  localparam int OUT_W   = NUM_LED + 3;

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b0;
  logic [1:0]         mode_i = '0;
  logic               mode_we = 1'b0;
  logic [CNT_W-1:0]   period_i = '0;
  logic               period_we = 1'b0;
  logic [PWM_W-1:0]   duty_i = '0;
  logic               duty_we = 1'b0;
  logic [NUM_LED-1:0] led;
  logic               tick;
  logic [1:0]         mode_o;

  always #5 clk = ~clk;

  led_pattern_gen #(
    .NUM_LED(NUM_LED), .CNT_W(CNT_W), .T_DEFAULT(26'd9),
    .PWM_W(PWM_W), .DUTY_DEFAULT(8'd128)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .mode_i(mode_i), .mode_we(mode_we),
    .period_i(period_i), .period_we(period_we),
    .duty_i(duty_i), .duty_we(duty_we),
    .led(led), .tick(tick), .mode_o(mode_o)
  );

  // ---------------- scoreboard ----------------
  logic [OUT_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: pattern state held as plain numbers
  // (blink lit flag, chase position, PWM phase), not as LED vectors.
  int m_mode, m_period, m_duty, m_cnt, m_pwm, m_pos;
  bit m_lit, m_pwm_on, m_tick;

  function automatic void model_reset();
    m_mode = 0; m_period = 9; m_duty = 128; m_cnt = 0; m_pwm = 0;
    m_pos = 0; m_lit = 0; m_pwm_on = 0; m_tick = 0;
  endfunction

  function automatic void model_step();
    bit load, wrap;
    int old_pwm, old_duty;
    if (rst) begin
      model_reset();
      return;
    end
    load     = mode_we || period_we;
    wrap     = en && !load && (m_cnt == m_period);
    old_pwm  = m_pwm;
    old_duty = m_duty;
    m_tick   = wrap;
    if (load) m_cnt = 0;
    else if (en) m_cnt = wrap ? 0 : m_cnt + 1;
    if (en) begin
      m_pwm    = (m_pwm + 1) % (1 << PWM_W);
      m_pwm_on = (old_pwm < old_duty);
      if (wrap) begin
        m_lit = !m_lit;
        m_pos = (m_pos + 1) % NUM_LED;
      end
    end
    if (period_we) m_period = int'(period_i);
    if (duty_we)   m_duty   = int'(duty_i);
    if (mode_we) begin
      m_mode = int'(mode_i);
      m_pwm = 0; m_lit = 0; m_pos = 0; m_pwm_on = 0;
    end
  endfunction

  function automatic logic [OUT_W-1:0] model_out();
    logic [NUM_LED-1:0] l;
    case (m_mode)
      1:       l = m_lit ? '1 : '0;
      2:       l = NUM_LED'(1 << m_pos);
      3:       l = m_pwm_on ? '1 : '0;
      default: l = '0;
    endcase
    return {l, m_tick, 2'(m_mode)};
  endfunction

  // Monitor: every clock presents one output word; compare it to the queue.
  always @(posedge clk) begin
    logic [OUT_W-1:0] exp_v, act_v;
    #2;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {led, tick, mode_o};
      cyc++;
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL out_cycle_%0d led/tick/mode act %b/%b/%0d exp %b/%b/%0d",
                 cyc, act_v[OUT_W-1:3], act_v[2], act_v[1:0],
                 exp_v[OUT_W-1:3], exp_v[2], exp_v[1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic e, input logic [1:0] mi,
                       input logic mwe, input logic [CNT_W-1:0] pi,
                       input logic pwe, input logic [PWM_W-1:0] di,
                       input logic dwe);
    @(negedge clk);
    #1;
    rst = r; en = e; mode_i = mi; mode_we = mwe;
    period_i = pi; period_we = pwe; duty_i = di; duty_we = dwe;
    model_step();
    exp_q.push_back(model_out());
  endtask

  task automatic run(input int n, input logic e);
    for (int i = 0; i < n; i++) drive(1'b0, e, 2'd0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  // Any n consecutive PWM cycles with n a multiple of 256 see each counter
  // value n/256 times, so the lit count is fixed by duty alone.
  task automatic pwm_window(input int n, input int exp_on, input string name);
    int on_cnt = 0;
    for (int i = 0; i < n; i++) begin
      run(1, 1'b1);
      @(posedge clk);
      #3;
      if (led[0] === 1'b1) on_cnt++;
    end
    checks++;
    if (on_cnt != exp_on) begin
      errors++;
      $display("FAIL %s on_count act %0d exp %0d", name, on_cnt, exp_on);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    // Reset held with every strobe active: reset must win.
    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'b1, 2'd2, 1'b1, 26'd3, 1'b1, 8'd7, 1'b1);
    run(12, 1'b1);

    // BLINK at default period 9.
    drive(1'b0, 1'b1, 2'd1, 1'b1, '0, 1'b0, '0, 1'b0);
    run(25, 1'b1);

    // CHASE with a 15-cycle freeze in the middle.
    drive(1'b0, 1'b1, 2'd2, 1'b1, '0, 1'b0, '0, 1'b0);
    run(35, 1'b1);
    run(15, 1'b0);
    run(30, 1'b1);

    // PWM duty sweeps.
    drive(1'b0, 1'b1, 2'd0, 1'b0, '0, 1'b0, 8'd64, 1'b1);
    drive(1'b0, 1'b1, 2'd3, 1'b1, '0, 1'b0, '0, 1'b0);
    pwm_window(256, 64, "pwm_duty64");
    drive(1'b0, 1'b1, 2'd0, 1'b0, '0, 1'b0, 8'd0, 1'b1);
    pwm_window(512, 0, "pwm_duty0");
    drive(1'b0, 1'b1, 2'd0, 1'b0, '0, 1'b0, 8'd255, 1'b1);
    pwm_window(256, 255, "pwm_duty255");

    // Period reload in BLINK while cnt is 7, then period 0.
    drive(1'b0, 1'b1, 2'd1, 1'b1, '0, 1'b0, '0, 1'b0);
    run(7, 1'b1);
    drive(1'b0, 1'b1, 2'd0, 1'b0, 26'd3, 1'b1, '0, 1'b0);
    run(10, 1'b1);
    drive(1'b0, 1'b1, 2'd0, 1'b0, 26'd0, 1'b1, '0, 1'b0);
    run(8, 1'b1);

    // Reset against a mode write, then mode+period written together.
    drive(1'b1, 1'b1, 2'd2, 1'b1, '0, 1'b0, '0, 1'b0);
    run(4, 1'b1);
    drive(1'b0, 1'b1, 2'd2, 1'b1, 26'd4, 1'b1, '0, 1'b0);
    run(14, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 99) < 85),
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 39) == 0),
            CNT_W'($urandom_range(0, 12)),
            ($urandom_range(0, 59) == 0),
            PWM_W'($urandom_range(0, 255)),
            ($urandom_range(0, 49) == 0));
    end

    @(posedge clk);
    #4;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain left %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
